// File: rtl/pipe_arith_hs.sv
// Three-stage pipeline computing f = ((a+b) + (c op d)) * d, modulo 2^N.
// Valid/ready flow control with bubble collapsing, occupancy and done count.
module pipe_arith_hs #(
  parameter int N     = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     c,
  input  logic [N-1:0]     d,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     f,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] done_cnt
);

  logic             v1, v2, v3;
  logic             nv1, nv2, nv3;
  logic             r1, r2, r3, r4;
  logic [N-1:0]     x1, x2, d1;
  logic [N-1:0]     x3, d2;
  logic [N-1:0]     f_q;
  logic [1:0]       occ_q;
  logic [CNT_W-1:0] cnt_q;

  // An empty stage always accepts, so bubbles collapse under a stall.
  assign r4 = out_ready;
  assign r3 = !v3 || r4;
  assign r2 = !v2 || r3;
  assign r1 = !v1 || r2;

  assign nv1 = r1 ? in_valid : v1;
  assign nv2 = r2 ? v1 : v2;
  assign nv3 = r3 ? v2 : v3;

  assign in_ready  = r1;
  assign out_valid = v3;
  assign f         = f_q;
  assign occ       = occ_q;
  assign done_cnt  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= nv1;
      v2 <= nv2;
      v3 <= nv3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1 <= '0;
      x2 <= '0;
      d1 <= '0;
    end else if (r1) begin
      x1 <= a + b;
      x2 <= mode ? c + d : c - d;
      d1 <= d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x3 <= '0;
      d2 <= '0;
    end else if (r2) begin
      x3 <= x1 + x2;
      d2 <= d1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= '0;
    end else if (r3) begin
      f_q <= x3 * d2;
    end
  end

  // occ tracks the valid bits being loaded this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= 2'd0;
    end else begin
      occ_q <= {1'b0, nv1} + {1'b0, nv2} + {1'b0, nv3};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (v3 && out_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_arith_hs.sv
// Directed bench for pipe_arith_hs: streaming, wrap, backpressure,
// bubble collapse, done counter wrap and mid-stream reset.
module tb_pipe_arith_hs;

  localparam int N     = 10;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a, b, c, d;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     f;
  logic [1:0]       occ;
  logic [CNT_W-1:0] done_cnt;

  int n_vec;
  int n_err;

  int ta[8], tb_[8], tc[8], td[8], tm[8], te[8];
  int nset;

  pipe_arith_hs #(.N(N), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f        (f),
    .occ      (occ),
    .done_cnt (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int va, input int vb, input int vc,
                       input int vd, input int vm);
    in_valid = 1'b1;
    a        = N'(va);
    b        = N'(vb);
    c        = N'(vc);
    d        = N'(vd);
    mode     = vm[0];
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    c        = '0;
    d        = '0;
    mode     = 1'b0;
  endtask

  task automatic put(input int i, input int va, input int vb, input int vc,
                     input int vd, input int vm, input int ve);
    ta[i] = va; tb_[i] = vb; tc[i] = vc;
    td[i] = vd; tm[i]  = vm; te[i] = ve;
  endtask

  // Stream nset loaded vectors with out_ready=1 and check results in order.
  task automatic run_batch(input string tag);
    int idx;
    int k;
    idx = 0;
    k   = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && k < nset; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        check(tag, int'(f), te[k]);
        k++;
      end
      if (idx < nset && in_ready) begin
        drive(ta[idx], tb_[idx], tc[idx], td[idx], tm[idx]);
        idx++;
      end else begin
        idle();
      end
    end
    check({tag, "_count"}, k, nset);
  endtask

  initial begin
    int idx;
    int k;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_f", int'(f), 0);
    check("rst_occ", int'(occ), 0);
    check("rst_done", int'(done_cnt), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;

    // Back-to-back streaming with latency checks
    @(negedge clk);
    out_ready = 1'b1;
    drive(10, 20, 30, 20, 0);
    @(negedge clk);
    check("lat_e0_valid", int'(out_valid), 0);
    check("lat_e0_occ", int'(occ), 1);
    drive(5, 15, 25, 10, 0);
    @(negedge clk);
    check("lat_e1_valid", int'(out_valid), 0);
    drive(1, 2, 4, 3, 0);
    @(negedge clk);
    idle();
    check("s1_valid", int'(out_valid), 1);
    check("s1_f", int'(f), 800);
    @(negedge clk);
    check("s2_valid", int'(out_valid), 1);
    check("s2_f", int'(f), 350);
    @(negedge clk);
    check("s3_valid", int'(out_valid), 1);
    check("s3_f", int'(f), 12);
    @(negedge clk);
    check("s_end_valid", int'(out_valid), 0);
    check("s_done", int'(done_cnt), 3);

    // Mode select and modulo wrap
    nset = 2;
    put(0, 10, 20, 30, 20, 1, 576);
    put(1, 0, 0, 3, 5, 0, 1014);
    run_batch("mode_wrap");
    @(negedge clk);
    check("mode_done", int'(done_cnt), 5);

    // Backpressure: only three accepted while stalled
    nset = 5;
    put(0, 1, 1, 1, 1, 1, 4);
    put(1, 2, 3, 4, 1, 0, 8);
    put(2, 0, 0, 0, 7, 1, 49);
    put(3, 1, 2, 3, 4, 1, 40);
    put(4, 9, 0, 0, 2, 0, 14);
    out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (in_ready && idx < nset) begin
        drive(ta[idx], tb_[idx], tc[idx], td[idx], tm[idx]);
        idx++;
      end
    end
    check("bp_accepted", idx, 3);
    check("bp_in_ready", int'(in_ready), 0);
    check("bp_occ", int'(occ), 3);
    check("bp_valid", int'(out_valid), 1);
    check("bp_f_held", int'(f), 4);
    @(negedge clk);
    check("bp_f_held2", int'(f), 4);
    out_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 30 && k < nset; cyc++) begin
      if (out_valid) begin
        check("bp_drain_f", int'(f), te[k]);
        k++;
      end
      if (idx < nset && in_ready) begin
        drive(ta[idx], tb_[idx], tc[idx], td[idx], tm[idx]);
        idx++;
      end else begin
        idle();
      end
      @(negedge clk);
    end
    check("bp_drain_count", k, 5);
    check("bp_done", int'(done_cnt), 10);
    check("bp_empty_valid", int'(out_valid), 0);

    // Bubble collapse behind a stalled stage 3
    drive(1, 1, 1, 1, 0);
    @(negedge clk);
    idle();
    k = 0;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("bub_reach_s3", int'(out_valid), 1);
    out_ready = 1'b0;
    check("bub_occ1", int'(occ), 1);
    check("bub_rdy1", int'(in_ready), 1);
    drive(2, 2, 2, 2, 0);
    @(negedge clk);
    check("bub_occ2", int'(occ), 2);
    check("bub_rdy2", int'(in_ready), 1);
    drive(3, 0, 0, 3, 1);
    @(negedge clk);
    idle();
    check("bub_occ3", int'(occ), 3);
    check("bub_rdy3", int'(in_ready), 0);
    check("bub_f_held", int'(f), 2);
    out_ready = 1'b1;
    check("bub_r0", int'(f), 2);
    @(negedge clk);
    check("bub_r1_valid", int'(out_valid), 1);
    check("bub_r1", int'(f), 8);
    @(negedge clk);
    check("bub_r2_valid", int'(out_valid), 1);
    check("bub_r2", int'(f), 18);
    @(negedge clk);
    check("bub_done", int'(done_cnt), 13);

    // Four more transfers: 17 in total wraps the 4-bit counter to 1
    nset = 4;
    put(0, 0, 0, 0, 1, 1, 1);
    put(1, 100, 200, 300, 3, 0, 1791 % 1024);
    put(2, 1023, 1, 0, 0, 1, 0);
    put(3, 512, 0, 0, 2, 1, 4);
    run_batch("cnt_batch");
    @(negedge clk);
    check("cnt_wrap", int'(done_cnt), 1);

    // Mid-stream reset with three in flight
    out_ready = 1'b0;
    drive(1, 2, 3, 4, 1);
    @(negedge clk);
    drive(5, 6, 7, 8, 0);
    @(negedge clk);
    drive(9, 9, 9, 9, 1);
    @(negedge clk);
    idle();
    check("mr_occ_full", int'(occ), 3);
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", int'(out_valid), 0);
    check("mr_f", int'(f), 0);
    check("mr_occ", int'(occ), 0);
    check("mr_done", int'(done_cnt), 0);
    check("mr_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (out_valid) k++;
    end
    check("mr_no_stale", k, 0);
    check("mr_done_after", int'(done_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
